// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus between the fetch sequencer (master) and a
// variable-latency instruction memory (slave).
//   req   master -> slave   fetch request valid
//   addr  master -> slave   fetch address; held while req=1 and rdy=0,
//                           except when a redirect abandons the request
//   rdy   slave  -> master  data valid this cycle for the current request
//   data  slave  -> master  fetched 16-bit instruction
interface fetch_sequencer_if;
    logic        req;
    logic [15:0] addr;
    logic        rdy;
    logic [15:0] data;

    modport master (output req, output addr, input rdy, input data);
    modport slave  (input req, input addr, output rdy, output data);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the 16-bit core: owns the architectural PC, issues
// requests to a variable-latency instruction memory, registers the IF/ID
// stage, absorbs hazard stalls with a one-entry skid buffer, applies
// branch redirects and parks the front end on HLT.
// Ports:
//   clk             clock, all state on rising edge
//   rst             asynchronous active-high reset
//   stall           hazard unit: hold IF/ID outputs and PC
//   redirect_valid  branch resolved taken this cycle
//   redirect_pc     branch target (even address)
//   imem            instruction-memory bus (master side)
//   if_valid        IF/ID holds a live instruction
//   if_instr        IF/ID instruction
//   if_pc           address of if_instr
//   if_pc_plus2     if_pc + 2, wrapping mod 2^16
//   halted          front end parked on HLT
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OPC  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [15:0]       redirect_pc,
    fetch_sequencer_if.master imem,
    output logic              if_valid,
    output logic [15:0]       if_instr,
    output logic [15:0]       if_pc,
    output logic [15:0]       if_pc_plus2,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        started;
    logic        req;
    logic        accept;
    logic        data_hlt;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;
    logic        skid_hlt;

    assign pc_plus2    = pc + 16'd2;
    assign if_pc_plus2 = if_pc + 16'd2;
    assign data_hlt    = (imem.data[15:12] == HLT_OPC);
    // A redirect makes the same-cycle response stale, so it is never accepted.
    assign accept      = req & imem.rdy & ~redirect_valid;
    assign imem.req    = req;
    assign imem.addr   = pc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        if (stall) begin
                            state_next = HOLD;
                        end else if (data_hlt) begin
                            state_next = HALT;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_next = skid_hlt ? HALT : FETCH;
                    end
                end
                HALT:    state_next = HALT;
                default: state_next = FETCH;
            endcase
        end
    end

    // Output logic. The request is held off for one cycle after reset
    // release so that any response still in flight from before the reset
    // lands while req=0 and is ignored. A full skid (HOLD) never requests.
    always_comb begin
        req    = 1'b0;
        halted = 1'b0;
        case (state)
            FETCH:   req    = started;
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // PC, skid buffer and IF/ID stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started    <= 1'b0;
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= 16'h0000;
            if_pc      <= 16'h0000;
            skid_instr <= 16'h0000;
            skid_pc    <= 16'h0000;
            skid_hlt   <= 1'b0;
        end else begin
            started <= 1'b1;
            if (redirect_valid) begin
                // Flush IF/ID even under stall; the skid is dropped by
                // leaving HOLD.
                pc       <= {redirect_pc[15:1], 1'b0};
                if_valid <= 1'b0;
            end else begin
                case (state)
                    FETCH: begin
                        if (accept) begin
                            if (!stall) begin
                                if_valid <= 1'b1;
                                if_instr <= imem.data;
                                if_pc    <= pc;
                            end else begin
                                skid_instr <= imem.data;
                                skid_pc    <= pc;
                                skid_hlt   <= data_hlt;
                            end
                            // PC stays on the HLT address while parked.
                            if (!data_hlt) begin
                                pc <= pc_plus2;
                            end
                        end else if (!stall) begin
                            if_valid <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            if_valid <= 1'b1;
                            if_instr <= skid_instr;
                            if_pc    <= skid_pc;
                        end
                    end
                    HALT: begin
                        if (!stall) begin
                            if_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
